// File: rtl/esc_pkg.sv
// Shared constants for the escape-mode LPDT receive path.
// Holds the FSM encoding and the byte / byte-counter widths.
// No logic; imported by the deserializer and its FIFO.
package esc_pkg;

   localparam int LPDT_BYTE_W = 8;
   localparam int RXCNT_W     = 16;

   // FSM encoding for the deserializer (kept as plain constants for legacy tools)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_END   = 2'd2;

endpackage

// File: rtl/esc_rx_fifo.sv
// Synchronous byte FIFO between the LPDT deserializer and the protocol layer.
// Latency: a pushed entry is visible at the head in the cycle after the push edge.
// Backpressure: pop is ignored when empty; push is dropped when full unless a pop frees a slot on the same edge.
module esc_rx_fifo
   import esc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = LPDT_BYTE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head is forced to zero when empty so the consumer never sees stale or unreset storage.
   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; reset discards any buffered entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the head is gated by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/esc_lpdt_deserializer.sv
// LPDT bit-to-byte deserializer (LSB first) with byte FIFO and burst/partial/overflow flags; optional ESC_LPDT_BYTECNT_EN builds the per-burst byte counter.
// Latency: byte valid on RxDataEsc in the cycle after its 8th bit is sampled; burst-end pulses one cycle after the terminating edge.
// Backpressure: valid/ready pop; bytes arriving while the FIFO is full (and not popping) are dropped and ErrOverflowEsc is set.
module esc_lpdt_deserializer
   import esc_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   RxClkEsc,
   input  logic                   RST,
   input  logic                   RxLpdtEsc,
   input  logic                   EscBit,
   input  logic                   LpFsmStop,
   input  logic                   RxReadyEsc,
   output logic [LPDT_BYTE_W-1:0] RxDataEsc,
   output logic                   RxValidEsc,
   output logic                   RxBurstEnd,
   output logic                   ErrPartialByte,
   output logic                   ErrOverflowEsc,
   output logic [RXCNT_W-1:0]     RxByteCount
);

   logic [1:0]             state;
   logic [LPDT_BYTE_W-1:0] shreg;
   logic [2:0]             bit_cnt;
   logic                   take_bit;
   logic                   burst_start;
   logic [LPDT_BYTE_W-1:0] shift_nxt;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;

   // A bit is consumed whenever the decoder is in LPDT and no stop has been seen.
   assign take_bit    = RxLpdtEsc & ~LpFsmStop;
   assign burst_start = (state == ST_IDLE) & take_bit;
   assign shift_nxt   = {EscBit, shreg[LPDT_BYTE_W-1:1]};

   // The 8th bit completes the byte, so push the value being shifted in, not the register.
   assign push = (state == ST_SHIFT) & take_bit & (bit_cnt == 3'd7);
   assign pop  = RxValidEsc & RxReadyEsc;

   // End-of-burst flags are decoded from the registered state, giving a one-cycle pulse.
   assign RxBurstEnd     = (state == ST_END);
   assign ErrPartialByte = (state == ST_END) & (bit_cnt != 3'd0);
   assign RxValidEsc     = ~fifo_empty;

   // Burst FSM, shift register and bit counter.
   always_ff @(posedge RxClkEsc) begin
      if (RST) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take_bit) begin
                  state   <= ST_SHIFT;
                  shreg   <= shift_nxt;
                  bit_cnt <= 3'd1;
               end
            end
            ST_SHIFT: begin
               if (take_bit) begin
                  shreg   <= shift_nxt;
                  bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  // Terminating edge samples nothing; bit_cnt is kept for the partial check in END.
                  state <= ST_END;
               end
            end
            ST_END: begin
               state   <= ST_IDLE;
               shreg   <= '0;
               bit_cnt <= '0;
            end
            default: begin
               state   <= ST_IDLE;
               shreg   <= '0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // Sticky overflow: set on a dropped byte, cleared only by reset or a new burst.
   always_ff @(posedge RxClkEsc) begin
      if (RST) begin
         ErrOverflowEsc <= 1'b0;
      end else if (burst_start) begin
         ErrOverflowEsc <= 1'b0;
      end else if (push & fifo_full & ~pop) begin
         ErrOverflowEsc <= 1'b1;
      end
   end

   esc_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (LPDT_BYTE_W)
   ) u_fifo (
      .clk       (RxClkEsc),
      .rst       (RST),
      .push      (push),
      .push_data (shift_nxt),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_data (RxDataEsc)
   );

`ifdef ESC_LPDT_BYTECNT_EN
   logic [RXCNT_W-1:0] byte_cnt;
   logic               push_ok;

   // A push is accepted when there is room or a same-edge pop makes room.
   assign push_ok = push & (~fifo_full | pop);

   // Per-burst byte counter: cleared at burst start, saturating, held after the burst.
   always_ff @(posedge RxClkEsc) begin
      if (RST) begin
         byte_cnt <= '0;
      end else if (burst_start) begin
         byte_cnt <= '0;
      end else if (push_ok && (byte_cnt != {RXCNT_W{1'b1}})) begin
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

   assign RxByteCount = byte_cnt;
`else
   assign RxByteCount = '0;
`endif

endmodule

// File: tb/tb_esc_lpdt_deserializer.sv
// Directed self-checking bench for esc_lpdt_deserializer.
// Inputs change 1 time unit after the rising edge; outputs are compared there too.
// Expected byte-counter values follow the ESC_LPDT_BYTECNT_EN build option.
module tb_esc_lpdt_deserializer;

   logic        RxClkEsc = 1'b0;
   logic        RST = 1'b1;
   logic        RxLpdtEsc = 1'b0;
   logic        EscBit = 1'b0;
   logic        LpFsmStop = 1'b0;
   logic        RxReadyEsc = 1'b0;
   logic [7:0]  RxDataEsc;
   logic        RxValidEsc;
   logic        RxBurstEnd;
   logic        ErrPartialByte;
   logic        ErrOverflowEsc;
   logic [15:0] RxByteCount;

   int tests = 0;
   int fails = 0;

`ifdef ESC_LPDT_BYTECNT_EN
   localparam logic [15:0] EXP_CNT3 = 16'd3;
   localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
   localparam logic [15:0] EXP_CNT3 = 16'd0;
   localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

   esc_lpdt_deserializer #(.FIFO_DEPTH(4)) dut (
      .RxClkEsc       (RxClkEsc),
      .RST            (RST),
      .RxLpdtEsc      (RxLpdtEsc),
      .EscBit         (EscBit),
      .LpFsmStop      (LpFsmStop),
      .RxReadyEsc     (RxReadyEsc),
      .RxDataEsc      (RxDataEsc),
      .RxValidEsc     (RxValidEsc),
      .RxBurstEnd     (RxBurstEnd),
      .ErrPartialByte (ErrPartialByte),
      .ErrOverflowEsc (ErrOverflowEsc),
      .RxByteCount    (RxByteCount)
   );

   always #5 RxClkEsc = ~RxClkEsc;

   task automatic step();
      @(posedge RxClkEsc);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         RxLpdtEsc = 1'b1;
         EscBit    = b[i];
         step();
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      step();
      tests++; if (RxDataEsc !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", RxDataEsc); end
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", RxValidEsc); end
      tests++; if (RxBurstEnd !== 1'b0) begin fails++; $display("FAIL reset_burst_end got %b exp 0", RxBurstEnd); end
      tests++; if (ErrPartialByte !== 1'b0) begin fails++; $display("FAIL reset_partial got %b exp 0", ErrPartialByte); end
      tests++; if (ErrOverflowEsc !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", ErrOverflowEsc); end
      tests++; if (RxByteCount !== 16'h0000) begin fails++; $display("FAIL reset_bytecount got %h exp 0000", RxByteCount); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_single_byte();
      RxReadyEsc = 1'b1;
      send_byte(8'hA5);
      tests++; if (RxValidEsc !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", RxValidEsc); end
      tests++; if (RxDataEsc !== 8'hA5) begin fails++; $display("FAIL single_data got %h exp a5", RxDataEsc); end
      RxLpdtEsc = 1'b0;
      step();
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL single_popped got %b exp 0", RxValidEsc); end
      tests++; if (RxBurstEnd !== 1'b1) begin fails++; $display("FAIL single_burst_end got %b exp 1", RxBurstEnd); end
      tests++; if (ErrPartialByte !== 1'b0) begin fails++; $display("FAIL single_partial got %b exp 0", ErrPartialByte); end
      step();
      tests++; if (RxBurstEnd !== 1'b0) begin fails++; $display("FAIL single_burst_end_width got %b exp 0", RxBurstEnd); end
   endtask

   task automatic test_partial();
      logic [2:0] tail;
      tail = 3'b011;
      RxReadyEsc = 1'b1;
      send_byte(8'h3C);
      tests++; if (RxDataEsc !== 8'h3C || RxValidEsc !== 1'b1) begin fails++; $display("FAIL partial_data got %h/%b exp 3c/1", RxDataEsc, RxValidEsc); end
      for (int i = 0; i < 3; i++) begin
         EscBit = tail[i];
         step();
      end
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL partial_no_extra_byte got %b exp 0", RxValidEsc); end
      LpFsmStop = 1'b1;
      step();
      tests++; if (RxBurstEnd !== 1'b1) begin fails++; $display("FAIL partial_burst_end got %b exp 1", RxBurstEnd); end
      tests++; if (ErrPartialByte !== 1'b1) begin fails++; $display("FAIL partial_flag got %b exp 1", ErrPartialByte); end
      RxLpdtEsc = 1'b0;
      LpFsmStop = 1'b0;
      step();
      tests++; if (ErrPartialByte !== 1'b0) begin fails++; $display("FAIL partial_flag_width got %b exp 0", ErrPartialByte); end
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL partial_discarded got %b exp 0", RxValidEsc); end
   endtask

   task automatic test_overflow();
      RxReadyEsc = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_byte(8'(k + 1));
         if (k == 3) begin
            tests++; if (ErrOverflowEsc !== 1'b0) begin fails++; $display("FAIL ovf_early got %b exp 0", ErrOverflowEsc); end
         end
      end
      tests++; if (ErrOverflowEsc !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", ErrOverflowEsc); end
      RxLpdtEsc = 1'b0;
      step();
      step();
      RxReadyEsc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tests++; if (RxValidEsc !== 1'b1 || RxDataEsc !== 8'(k + 1)) begin fails++; $display("FAIL ovf_pop%0d got %h/%b exp %h/1", k, RxDataEsc, RxValidEsc, 8'(k + 1)); end
         step();
      end
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL ovf_drained got %b exp 0", RxValidEsc); end
      tests++; if (ErrOverflowEsc !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", ErrOverflowEsc); end
      RxReadyEsc = 1'b0;
   endtask

   task automatic test_full_with_pop();
      logic [7:0] b;
      RxReadyEsc = 1'b0;
      for (int k = 0; k < 4; k++) begin
         b = 8'h10 + 8'(k);
         for (int i = 0; i < 8; i++) begin
            RxLpdtEsc = 1'b1;
            EscBit    = b[i];
            step();
            if (k == 0 && i == 0) begin
               tests++; if (ErrOverflowEsc !== 1'b0) begin fails++; $display("FAIL ovf_clear_on_start got %b exp 0", ErrOverflowEsc); end
            end
         end
      end
      b = 8'h14;
      for (int i = 0; i < 7; i++) begin
         EscBit = b[i];
         step();
      end
      EscBit     = b[7];
      RxReadyEsc = 1'b1;
      step();
      tests++; if (ErrOverflowEsc !== 1'b0) begin fails++; $display("FAIL fullpop_no_ovf got %b exp 0", ErrOverflowEsc); end
      tests++; if (RxDataEsc !== 8'h11 || RxValidEsc !== 1'b1) begin fails++; $display("FAIL fullpop_head got %h/%b exp 11/1", RxDataEsc, RxValidEsc); end
      RxLpdtEsc = 1'b0;
      for (int j = 2; j < 5; j++) begin
         step();
         tests++; if (RxDataEsc !== 8'h10 + 8'(j)) begin fails++; $display("FAIL fullpop_order%0d got %h exp %h", j, RxDataEsc, 8'h10 + 8'(j)); end
      end
      step();
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL fullpop_drained got %b exp 0", RxValidEsc); end
      tests++; if (ErrOverflowEsc !== 1'b0) begin fails++; $display("FAIL fullpop_ovf_final got %b exp 0", ErrOverflowEsc); end
      RxReadyEsc = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      RxReadyEsc = 1'b0;
      send_byte(8'h5A);
      send_byte(8'hC3);
      for (int i = 0; i < 4; i++) begin
         EscBit = 1'b1;
         step();
      end
      tests++; if (RxValidEsc !== 1'b1 || RxDataEsc !== 8'h5A) begin fails++; $display("FAIL rstmid_pre got %h/%b exp 5a/1", RxDataEsc, RxValidEsc); end
      RST = 1'b1;
      step();
      tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b exp 0", RxValidEsc); end
      tests++; if (RxDataEsc !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h exp 00", RxDataEsc); end
      tests++; if (RxBurstEnd !== 1'b0 || ErrPartialByte !== 1'b0) begin fails++; $display("FAIL rstmid_flags got %b%b exp 00", RxBurstEnd, ErrPartialByte); end
      RST       = 1'b0;
      RxLpdtEsc = 1'b0;
      step();
      RxReadyEsc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RxLpdtEsc = 1'b1;
         EscBit    = 1'b1;
         step();
         if (i == 3) begin
            tests++; if (RxValidEsc !== 1'b0) begin fails++; $display("FAIL rstmid_bitcnt got %b exp 0", RxValidEsc); end
         end
      end
      tests++; if (RxValidEsc !== 1'b1 || RxDataEsc !== 8'hFF) begin fails++; $display("FAIL rstmid_ff got %h/%b exp ff/1", RxDataEsc, RxValidEsc); end
      RxLpdtEsc = 1'b0;
      step();
      tests++; if (RxBurstEnd !== 1'b1 || ErrPartialByte !== 1'b0) begin fails++; $display("FAIL rstmid_end got %b%b exp 10", RxBurstEnd, ErrPartialByte); end
      step();
   endtask

   task automatic test_back_to_back();
      RxReadyEsc = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send_byte(8'h61 + 8'(k));
         tests++; if (RxDataEsc !== 8'h61 + 8'(k)) begin fails++; $display("FAIL b2b_byte%0d got %h exp %h", k, RxDataEsc, 8'h61 + 8'(k)); end
      end
      RxLpdtEsc = 1'b0;
      step();
      tests++; if (RxBurstEnd !== 1'b1) begin fails++; $display("FAIL b2b_end got %b exp 1", RxBurstEnd); end
      tests++; if (RxByteCount !== EXP_CNT3) begin fails++; $display("FAIL bytecount_end got %h exp %h", RxByteCount, EXP_CNT3); end
      step();
      tests++; if (RxByteCount !== EXP_CNT3) begin fails++; $display("FAIL bytecount_hold got %h exp %h", RxByteCount, EXP_CNT3); end
      send_byte(8'h7E);
      tests++; if (RxValidEsc !== 1'b1 || RxDataEsc !== 8'h7E) begin fails++; $display("FAIL b2b_restart got %h/%b exp 7e/1", RxDataEsc, RxValidEsc); end
      tests++; if (RxByteCount !== EXP_CNT1) begin fails++; $display("FAIL bytecount_restart got %h exp %h", RxByteCount, EXP_CNT1); end
      RxLpdtEsc = 1'b0;
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_partial();
      test_overflow();
      test_full_with_pop();
      test_reset_mid_burst();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
